// File: rtl/hazard_pkg.sv
// Shared opcode classes, sequencer state encoding and drain depth for hazard_ctrl.
package hazard_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] DRAIN_DEPTH = 2'd3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    DONE     = 2'd3
  } state_e;

endpackage

// File: rtl/reg_use_decode.sv
// Opcode-class decode: which source register fields the instruction in ID reads.
module reg_use_decode
  import hazard_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic       uses_rs1_o,
  output logic       uses_rs2_o
);

  always_comb begin
    uses_rs1_o = 1'b0;
    uses_rs2_o = 1'b0;
    case (opcode_i)
      OP_RTYPE, OP_STORE, OP_BRANCH: begin
        uses_rs1_o = 1'b1;
        uses_rs2_o = 1'b1;
      end
      OP_ITYPE, OP_LOAD: uses_rs1_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes, memory waits, drain/halt.
// Optional performance counters are built only when PERF_CNT_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_id_i,
  input  logic        ex_memread_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        branch_taken_i,
  input  logic        mem_req_i,
  input  logic        mem_ack_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        ifid_flush_o,
  output logic        idex_bubble_o,
  output logic        exmem_hold_o,
  output logic        halt_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  state_e     state_q, state_d;
  logic [1:0] drain_q, drain_d;
  logic       uses_rs1, uses_rs2;
  logic       lu, mem_wait;

  reg_use_decode u_reg_use_decode (
    .opcode_i   (instr_id_i[6:0]),
    .uses_rs1_o (uses_rs1),
    .uses_rs2_o (uses_rs2)
  );

  assign lu = ex_memread_i && (ex_rd_i != 5'd0) &&
              ((uses_rs1 && (instr_id_i[19:15] == ex_rd_i)) ||
               (uses_rs2 && (instr_id_i[24:20] == ex_rd_i)));

  assign mem_wait = mem_req_i && !mem_ack_i;

  always_comb begin
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    exmem_hold_o  = 1'b0;
    halt_o        = 1'b0;
    state_d       = state_q;
    drain_d       = drain_q;
    case (state_q)
      RUN: begin
        if (mem_wait) begin
          exmem_hold_o = 1'b1;
          state_d      = MEM_WAIT;
        end else if (lu) begin
          idex_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
          ifid_flush_o = 1'b1;
          ifid_write_o = 1'b1;
          pc_write_o   = 1'b1;
        end else if (instr_id_i == 32'h0000_0000) begin
          state_d = DRAIN;
          drain_d = DRAIN_DEPTH;
        end else begin
          pc_write_o   = 1'b1;
          ifid_write_o = 1'b1;
        end
      end
      MEM_WAIT: begin
        exmem_hold_o = 1'b1;
        if (mem_ack_i) state_d = RUN;
      end
      DRAIN: begin
        idex_bubble_o = 1'b1;
        // The cycle that moves the last in-flight instruction out goes straight to DONE.
        if (mem_wait) begin
          exmem_hold_o = 1'b1;
        end else if (drain_q <= 2'd1) begin
          drain_d = '0;
          state_d = DONE;
        end else begin
          drain_d = drain_q - 2'd1;
        end
      end
      DONE: begin
        halt_o        = 1'b1;
        idex_bubble_o = 1'b1;
        ifid_flush_o  = 1'b1;
      end
      default: state_d = RUN;
    endcase
    if (!rst_i) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
      exmem_hold_o  = 1'b0;
      halt_o        = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Flushes outside DONE can only come from a taken branch in RUN.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write_o) stall_cnt_d = stall_cnt_q + 32'd1;
    if (ifid_flush_o && (state_q == RUN)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (counter expectations follow PERF_CNT_EN).
module tb_hazard_ctrl;

`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [31:0] I_NOP  = 32'h0000_0013; // addi x0,x0,0
  localparam logic [31:0] I_ADD  = 32'h0072_8333; // add  x6,x5,x7
  localparam logic [31:0] I_ADDI = 32'h0081_0093; // addi x1,x2,8 (rs2 field = 8)
  localparam logic [31:0] I_SW   = 32'h0091_8023; // sw   x9,0(x3)
  localparam logic [31:0] I_ZERO = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] instr_id_i = I_NOP;
  logic        ex_memread_i = 1'b0;
  logic [4:0]  ex_rd_i = 5'd0;
  logic        branch_taken_i = 1'b0;
  logic        mem_req_i = 1'b0;
  logic        mem_ack_i = 1'b0;
  logic        pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, exmem_hold_o, halt_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned exp_stall = 0;
  int unsigned exp_flush = 0;

  always #5 clk_i = ~clk_i;

  hazard_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .instr_id_i     (instr_id_i),
    .ex_memread_i   (ex_memread_i),
    .ex_rd_i        (ex_rd_i),
    .branch_taken_i (branch_taken_i),
    .mem_req_i      (mem_req_i),
    .mem_ack_i      (mem_ack_i),
    .pc_write_o     (pc_write_o),
    .ifid_write_o   (ifid_write_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_bubble_o  (idex_bubble_o),
    .exmem_hold_o   (exmem_hold_o),
    .halt_o         (halt_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
  );

  // Drive one cycle's inputs just after the edge, then let outputs settle.
  task automatic apply(input logic [31:0] ins, input logic mr, input logic [4:0] rd,
                       input logic br, input logic req, input logic ack);
    instr_id_i = ins; ex_memread_i = mr; ex_rd_i = rd;
    branch_taken_i = br; mem_req_i = req; mem_ack_i = ack;
    #1;
  endtask

  // Account for what the coming edge adds to the counters, then cross it.
  task automatic adv(input bit st, input bit fl);
    if (st) exp_stall++;
    if (fl) exp_flush++;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    apply(I_NOP, 0, 0, 0, 0, 0);
    @(posedge clk_i); @(posedge clk_i); #1;
    checks++; if (pc_write_o !== 1'b0) begin failures++; $display("FAIL rst_pc_write got=%b exp=0", pc_write_o); end
    checks++; if (ifid_write_o !== 1'b0) begin failures++; $display("FAIL rst_ifid_write got=%b exp=0", ifid_write_o); end
    checks++; if (ifid_flush_o !== 1'b1) begin failures++; $display("FAIL rst_ifid_flush got=%b exp=1", ifid_flush_o); end
    checks++; if (idex_bubble_o !== 1'b1) begin failures++; $display("FAIL rst_bubble got=%b exp=1", idex_bubble_o); end
    checks++; if (exmem_hold_o !== 1'b0) begin failures++; $display("FAIL rst_hold got=%b exp=0", exmem_hold_o); end
    checks++; if (halt_o !== 1'b0) begin failures++; $display("FAIL rst_halt got=%b exp=0", halt_o); end
    checks++; if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin failures++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", stall_cnt_o, flush_cnt_o); end
    rst_i = 1'b1; exp_stall = 0; exp_flush = 0;
    apply(I_NOP, 0, 0, 0, 0, 0);
    checks++; if ({pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, exmem_hold_o} !== 5'b11000) begin failures++; $display("FAIL run_normal got=%b exp=11000", {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, exmem_hold_o}); end
    adv(0, 0);
  endtask

  task automatic test_load_use;
    apply(I_ADD, 1, 5'd5, 0, 0, 0);
    checks++; if ({pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o} !== 4'b0010) begin failures++; $display("FAIL lu_stall got=%b exp=0010", {pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o}); end
    adv(1, 0);
    apply(I_ADD, 0, 5'd0, 0, 0, 0);
    checks++; if ({pc_write_o, idex_bubble_o} !== 2'b10) begin failures++; $display("FAIL lu_after got=%b exp=10", {pc_write_o, idex_bubble_o}); end
    adv(0, 0);
    apply(I_ADD, 1, 5'd0, 0, 0, 0);
    checks++; if ({pc_write_o, idex_bubble_o} !== 2'b10) begin failures++; $display("FAIL lu_rd0 got=%b exp=10", {pc_write_o, idex_bubble_o}); end
    adv(0, 0);
    apply(I_ADD, 1, 5'd7, 0, 0, 0);
    checks++; if ({pc_write_o, idex_bubble_o} !== 2'b01) begin failures++; $display("FAIL lu_rs2 got=%b exp=01", {pc_write_o, idex_bubble_o}); end
    adv(1, 0);
  endtask

  task automatic test_no_false_stall;
    apply(I_ADDI, 1, 5'd8, 0, 0, 0);
    checks++; if ({pc_write_o, idex_bubble_o} !== 2'b10) begin failures++; $display("FAIL itype_rs2 got=%b exp=10", {pc_write_o, idex_bubble_o}); end
    adv(0, 0);
    apply(I_ADDI, 1, 5'd2, 0, 0, 0);
    checks++; if ({pc_write_o, idex_bubble_o} !== 2'b01) begin failures++; $display("FAIL itype_rs1 got=%b exp=01", {pc_write_o, idex_bubble_o}); end
    adv(1, 0);
    apply(I_SW, 1, 5'd9, 0, 0, 0);
    checks++; if ({pc_write_o, idex_bubble_o} !== 2'b01) begin failures++; $display("FAIL store_rs2 got=%b exp=01", {pc_write_o, idex_bubble_o}); end
    adv(1, 0);
    apply(I_NOP, 1, 5'd0, 0, 0, 0);
    checks++; if (stall_cnt_o !== (PERF ? exp_stall : 32'd0)) begin failures++; $display("FAIL stall_cnt_a got=%0d exp=%0d", stall_cnt_o, PERF ? exp_stall : 0); end
    adv(0, 0);
  endtask

  task automatic test_branch;
    apply(I_NOP, 0, 0, 1, 0, 0);
    checks++; if ({ifid_flush_o, pc_write_o, idex_bubble_o} !== 3'b110) begin failures++; $display("FAIL br_flush got=%b exp=110", {ifid_flush_o, pc_write_o, idex_bubble_o}); end
    adv(0, 1);
    apply(I_NOP, 0, 0, 0, 0, 0);
    checks++; if (ifid_flush_o !== 1'b0) begin failures++; $display("FAIL br_one_cycle got=%b exp=0", ifid_flush_o); end
    checks++; if (flush_cnt_o !== (PERF ? exp_flush : 32'd0)) begin failures++; $display("FAIL flush_cnt_a got=%0d exp=%0d", flush_cnt_o, PERF ? exp_flush : 0); end
    adv(0, 0);
  endtask

  task automatic test_branch_vs_lu;
    apply(I_ADD, 1, 5'd5, 1, 0, 0);
    checks++; if ({pc_write_o, ifid_flush_o, idex_bubble_o} !== 3'b001) begin failures++; $display("FAIL brlu_stall got=%b exp=001", {pc_write_o, ifid_flush_o, idex_bubble_o}); end
    adv(1, 0);
    apply(I_ADD, 0, 5'd0, 1, 0, 0);
    checks++; if ({pc_write_o, ifid_flush_o, idex_bubble_o} !== 3'b110) begin failures++; $display("FAIL brlu_flush got=%b exp=110", {pc_write_o, ifid_flush_o, idex_bubble_o}); end
    adv(0, 1);
    apply(I_NOP, 0, 0, 0, 0, 0);
    checks++; if (flush_cnt_o !== (PERF ? exp_flush : 32'd0)) begin failures++; $display("FAIL flush_cnt_b got=%0d exp=%0d", flush_cnt_o, PERF ? exp_flush : 0); end
    adv(0, 0);
  endtask

  task automatic test_mem_wait;
    for (int unsigned i = 0; i < 3; i++) begin
      apply(I_ADD, 1, 5'd5, (i == 2), 1, (i == 2));
      checks++; if ({exmem_hold_o, pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o} !== 5'b10000) begin failures++; $display("FAIL mem_hold_%0d got=%b exp=10000", i, {exmem_hold_o, pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o}); end
      adv(1, 0);
    end
    apply(I_NOP, 0, 0, 0, 0, 0);
    checks++; if ({exmem_hold_o, pc_write_o} !== 2'b01) begin failures++; $display("FAIL mem_release got=%b exp=01", {exmem_hold_o, pc_write_o}); end
    checks++; if (stall_cnt_o !== (PERF ? exp_stall : 32'd0)) begin failures++; $display("FAIL stall_cnt_b got=%0d exp=%0d", stall_cnt_o, PERF ? exp_stall : 0); end
    adv(0, 0);
  endtask

  task automatic test_drain_reset;
    apply(I_ZERO, 0, 0, 0, 0, 0);
    adv(1, 0);
    apply(I_ZERO, 0, 0, 0, 0, 0);
    checks++; if ({pc_write_o, idex_bubble_o, halt_o} !== 3'b010) begin failures++; $display("FAIL drn_enter got=%b exp=010", {pc_write_o, idex_bubble_o, halt_o}); end
    rst_i = 1'b0;
    #1;
    checks++; if ({pc_write_o, ifid_flush_o, idex_bubble_o, halt_o} !== 4'b0110) begin failures++; $display("FAIL drn_rst_out got=%b exp=0110", {pc_write_o, ifid_flush_o, idex_bubble_o, halt_o}); end
    checks++; if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin failures++; $display("FAIL drn_rst_cnt got=%0d/%0d exp=0/0", stall_cnt_o, flush_cnt_o); end
    @(posedge clk_i); #1;
    rst_i = 1'b1; exp_stall = 0; exp_flush = 0;
    apply(I_NOP, 0, 0, 0, 0, 0);
    checks++; if ({pc_write_o, ifid_write_o, halt_o} !== 3'b110) begin failures++; $display("FAIL drn_rst_run got=%b exp=110", {pc_write_o, ifid_write_o, halt_o}); end
    adv(0, 0);
  endtask

  task automatic test_drain;
    apply(I_ZERO, 0, 0, 0, 0, 0);
    checks++; if ({pc_write_o, ifid_write_o, halt_o} !== 3'b000) begin failures++; $display("FAIL drn_c0 got=%b exp=000", {pc_write_o, ifid_write_o, halt_o}); end
    adv(1, 0);
    for (int unsigned i = 1; i <= 3; i++) begin
      apply(I_ZERO, 0, 0, 0, 0, 0);
      checks++; if ({pc_write_o, ifid_write_o, idex_bubble_o, halt_o} !== 4'b0010) begin failures++; $display("FAIL drn_c%0d got=%b exp=0010", i, {pc_write_o, ifid_write_o, idex_bubble_o, halt_o}); end
      adv(1, 0);
    end
    apply(I_NOP, 0, 0, 0, 0, 0);
    checks++; if ({pc_write_o, ifid_write_o, idex_bubble_o, halt_o} !== 4'b0011) begin failures++; $display("FAIL drn_c4 got=%b exp=0011", {pc_write_o, ifid_write_o, idex_bubble_o, halt_o}); end
    adv(1, 0);
    apply(I_ADD, 0, 0, 1, 0, 0);
    checks++; if ({pc_write_o, ifid_write_o, halt_o} !== 3'b001) begin failures++; $display("FAIL done_sticky got=%b exp=001", {pc_write_o, ifid_write_o, halt_o}); end
    checks++; if (stall_cnt_o !== (PERF ? exp_stall : 32'd0)) begin failures++; $display("FAIL stall_cnt_c got=%0d exp=%0d", stall_cnt_o, PERF ? exp_stall : 0); end
    adv(1, 0);
  endtask

  task automatic test_drain_mem;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1; exp_stall = 0; exp_flush = 0;
    apply(I_ZERO, 0, 0, 0, 0, 0);
    adv(1, 0);
    apply(I_ZERO, 0, 0, 0, 1, 0);
    checks++; if ({exmem_hold_o, idex_bubble_o, halt_o} !== 3'b110) begin failures++; $display("FAIL dmem_hold got=%b exp=110", {exmem_hold_o, idex_bubble_o, halt_o}); end
    adv(1, 0);
    for (int unsigned i = 2; i <= 4; i++) begin
      apply(I_ZERO, 0, 0, 0, 0, 0);
      checks++; if ({exmem_hold_o, halt_o} !== 2'b00) begin failures++; $display("FAIL dmem_c%0d got=%b exp=00", i, {exmem_hold_o, halt_o}); end
      adv(1, 0);
    end
    apply(I_ZERO, 0, 0, 0, 0, 0);
    checks++; if (halt_o !== 1'b1) begin failures++; $display("FAIL dmem_halt got=%b exp=1", halt_o); end
    adv(1, 0);
  endtask

  initial begin
    test_reset;
    test_load_use;
    test_no_false_stall;
    test_branch;
    test_branch_vs_lu;
    test_mem_wait;
    test_drain_reset;
    test_drain;
    test_drain_mem;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage RV32 core. It decides each cycle whether the PC, IF/ID and ID/EX registers advance, hold, flush or take a bubble. It covers load-use hazards, taken branches resolved in ID, data-memory wait states and the end-of-program drain. It sits beside the decode stage and consumes the same opcode classes as the immediate generator: R-type, addi/srai, lw, sw, beq.

## Interface
- No parameters.
- clk_i  input  1  core clock
- rst_i  input  1  reset, asynchronous, active-low
- instr_id_i  input  32  instruction currently in IF/ID
- ex_memread_i  input  1  ID/EX holds a load
- ex_rd_i  input  5  ID/EX destination register
- branch_taken_i  input  1  beq in ID resolved taken this cycle
- mem_req_i  input  1  MEM stage access active
- mem_ack_i  input  1  data memory completes access this cycle
- pc_write_o  output  1  PC may update
- ifid_write_o  output  1  IF/ID may load
- ifid_flush_o  output  1  IF/ID loads a NOP
- idex_bubble_o  output  1  ID/EX loads a NOP, i.e. control zeroed
- exmem_hold_o  output  1  EX/MEM and MEM/WB hold
- halt_o  output  1  program fully retired
- stall_cnt_o  output  32  cycles with pc_write_o low
- flush_cnt_o  output  32  taken-branch flushes

## Operation
- **Register use, by opcode:**
  - R-type (0110011): uses rs1 and rs2.
  - I-type (0010011) and load (0000011): use rs1 only.
  - store (0100011) and branch (1100011): use rs1 and rs2.
  - any other opcode: uses neither.
- **Load-use hazard (lu):** ex_memread_i and ex_rd_i≠0, and ex_rd_i matches a used rs1 (instr[19:15]) or a used rs2 (instr[24:20]).
- **States:** RUN, MEM_WAIT, DRAIN, DONE.
- **RUN, checked in this priority order:**
  1. mem_req_i & !mem_ack_i: all holds asserted (pc_write_o=0, ifid_write_o=0, exmem_hold_o=1, idex_bubble_o=0). Next state MEM_WAIT.
  2. lu: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1. branch_taken_i is ignored this cycle.
  3. branch_taken_i: ifid_flush_o=1, pc_write_o=1.
  4. instr_id_i==32'h0000_0000: pc_write_o=0, ifid_write_o=0. Next state DRAIN, drain counter loaded with 3.
  5. Otherwise: pc_write_o=1, ifid_write_o=1, all other outputs 0.
- **MEM_WAIT:** all holds as in RUN rule 1.
  - Leaves to RUN the cycle after mem_ack_i=1; that ack cycle itself still holds.
  - Hazard and branch inputs are ignored in this state.
- **DRAIN:**
  - pc_write_o=0, ifid_write_o=0, idex_bubble_o=1.
  - The counter decrements each cycle that the later stages advance.
  - A memory wait inside DRAIN asserts exmem_hold_o and pauses the counter.
  - At 0, next state DONE.
- **DONE:** halt_o=1, all writes 0, bubbles 1. Only reset leaves this state.
- **Reset mid-operation:** returns to RUN immediately. The drain counter clears.

## Timing
- State is registered; all control outputs are combinational (Mealy) from state and inputs, valid in the same cycle.
- Load-use costs exactly 1 stall cycle. The next cycle sees a bubble in EX, so lu deasserts.
- Branch penalty is 1 flushed slot.
- Memory wait of N cycles (ack on the N-th) costs N frozen cycles.
- halt_o rises 4 cycles after the zero word is first seen in ID in RUN, absent memory waits.
- **Reset values while rst_i=0:**
  - pc_write_o=0, ifid_write_o=0, ifid_flush_o=1, idex_bubble_o=1
  - exmem_hold_o=0, halt_o=0
  - counters 0
- Counters are registered, increment on the clock edge, and wrap at 2^32.

## Configuration
- PERF_CNT_EN defined: stall_cnt_o and flush_cnt_o are live counters as above.
- PERF_CNT_EN undefined: both ports remain and are tied to 0; no counter flops are built.

## Structure
- **Package hazard_pkg:**
  - opcode constants OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH
  - state typedef (RUN, MEM_WAIT, DRAIN, DONE)
  - DRAIN_DEPTH=3
- **Sub-module reg_use_decode:** combinational, opcode in → uses_rs1/uses_rs2 out.

## Test plan
- **Load-use:** ex_memread_i=1, ex_rd_i=5, instr = add x6,x5,x7 → one cycle of pc_write_o=0 and idex_bubble_o=1, then normal flow. The same test with ex_rd_i=0 → no stall.
- **No false stall:** ex_rd_i=8, instr = addi x1,x2,... whose rs2 field equals 8 → no stall, because I-type ignores rs2.
- **Taken branch:** branch_taken_i=1, no hazard → ifid_flush_o=1 for 1 cycle; flush_cnt_o goes 0→1.
- **Branch vs. load-use:** branch_taken_i=1 together with lu → stall only, ifid_flush_o=0; the flush happens the next cycle.
- **Memory wait:** mem_req_i=1 with ack after 3 cycles → exmem_hold_o high for 3 cycles; stall_cnt_o increases by 3; lu is ignored meanwhile.
- **Drain and reset:** zero instruction in ID → halt_o=1 exactly 4 cycles later. Asserting rst_i low during DRAIN → halt_o=0, state RUN, counters 0.
